// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer arbiter.
// Holds the framebuffer geometry, the active-area limits, the arbiter state
// enumeration and the display address helper.
package vga_fb_arbiter_pkg;

    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned FB_WORDS = FB_W * FB_H;   // 19200

    localparam logic [9:0]  H_ACTIVE = 10'd640;
    localparam logic [9:0]  V_ACTIVE = 10'd480;

    typedef enum logic [1:0] {
        StIdle,     // no request or blocked cycle
        StGrant,    // access issued
        StResp      // read return pending
    } arb_state_e;

    // row*160 + col as shift-add (160 = 128 + 32). With row <= 119 and
    // col <= 159 the result never exceeds FB_WORDS-1.
    function automatic logic [16:0] disp_addr(input logic [7:0] row, input logic [7:0] col);
        logic [16:0] w_row;
        w_row = {9'd0, row};
        return (w_row << 7) + (w_row << 5) + {9'd0, col};
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req[1:0]     : requests (already masked by the caller)
//   i_en           : grants are only issued when 1
//   o_gnt[1:0]     : combinational one-hot grant (at most one bit set)
// The last-grant pointer resets to 1 so that requester 0 wins the first tie.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_last;   // index of the requester granted most recently

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// VGA framebuffer arbiter: shares one single-port RAM between the display
// scan-out and two round-robin requesters.
// Ports:
//   clk, reset                 : pixel clock, asynchronous active-low reset
//   CounterX, CounterY         : sync generator position
//   vblank_only                : serve requesters only outside the active area
//   req, we, addr0/1, wdata0/1 : requester interface (held until gnt)
//   gnt, err                   : grant pulse, out-of-range pulse (same cycle)
//   rvalid, rdata              : read return, one cycle after a read grant
//   mem_addr, mem_we, mem_wdata: registered RAM controls; mem_rdata has 1-cycle latency
//   pix, pix_valid             : display pixel and active-area flag
// Timing: the decision is taken in the cycle the counters/requests are
// presented; gnt, err and the mem_* controls for that access are all
// registered and appear together on the following cycle.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    CounterX,
    input  logic [9:0]    CounterY,
    input  logic          vblank_only,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix,
    output logic          pix_valid
);

    logic          w_active, w_slot, w_req_cycle;
    logic [1:0]    w_req_eff, w_gnt;
    logic          w_any, w_sel, w_we, w_oob;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [16:0]   w_disp_full;

    arb_state_e    r_state;
    logic [1:0]    r_gnt, r_gnt_rd, r_rvalid;
    logic          r_err, r_rd_err;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;
    logic [1:0]    r_slot_d, r_act_d;
    logic [DW-1:0] r_pix;
    logic          r_pix_valid;

    assign w_active    = (CounterX < H_ACTIVE) && (CounterY < V_ACTIVE);
    assign w_slot      = w_active && (CounterX[1:0] == 2'b00);
    assign w_req_cycle = !w_slot && (!vblank_only || !w_active);
    assign w_disp_full = disp_addr(CounterY[9:2], CounterX[9:2]);

    // The requester only sees gnt one cycle later and still holds req in that
    // cycle, so the requester granted last cycle is masked out.
    assign w_req_eff = req & ~r_gnt;

    rr_arb2 u_rr_arb2 (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_req   (w_req_eff),
        .i_en    (w_req_cycle),
        .o_gnt   (w_gnt)
    );

    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[1];
    assign w_addr  = w_sel ? addr1  : addr0;
    assign w_wdata = w_sel ? wdata1 : wdata0;
    assign w_we    = w_sel ? we[1]  : we[0];
    assign w_oob   = w_addr >= AW'(FB_WORDS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_gnt       <= 2'b00;
            r_gnt_rd    <= 2'b00;
            r_rvalid    <= 2'b00;
            r_err       <= 1'b0;
            r_rd_err    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_slot_d    <= 2'b00;
            r_act_d     <= 2'b00;
            r_pix       <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            if (w_any) begin
                r_state <= StGrant;
            end else if (r_state == StGrant && |r_gnt_rd) begin
                r_state <= StResp;
            end else begin
                r_state <= StIdle;
            end

            r_gnt    <= w_gnt;
            r_err    <= w_any & w_oob;
            r_gnt_rd <= w_gnt & {2{~w_we}};
            r_rvalid <= r_gnt_rd;
            r_rd_err <= r_err;

            if (w_slot) begin
                r_mem_addr <= AW'(w_disp_full);
                r_mem_we   <= 1'b0;
            end else if (w_any) begin
                r_mem_addr  <= w_addr;
                r_mem_we    <= w_we & ~w_oob;
                r_mem_wdata <= w_wdata;
            end else begin
                r_mem_we <= 1'b0;
            end

            // mem_rdata for a slot is valid two cycles after it; pix then
            // holds until the next slot four cycles later.
            r_slot_d    <= {r_slot_d[0], w_slot};
            r_act_d     <= {r_act_d[0], w_active};
            r_pix_valid <= r_act_d[1];
            if (r_slot_d[1]) begin
                r_pix <= mem_rdata;
            end
        end
    end

    assign gnt       = r_gnt;
    assign err       = r_err;
    assign rvalid    = r_rvalid;
    assign rdata     = (|r_rvalid && !r_rd_err) ? mem_rdata : '0;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign pix       = r_pix;
    assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: stimulus pushes expected grant,
// read-return and timed output checks; one monitor process compares them.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  CounterX = 10'd700;
    logic [9:0]  CounterY = 10'd500;
    logic        vblank_only = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [14:0] addr0 = '0;
    logic [14:0] addr1 = '0;
    logic [7:0]  wdata0 = '0;
    logic [7:0]  wdata1 = '0;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  rdata, mem_wdata, pix;
    logic [7:0]  mem_rdata = '0;
    logic        err, mem_we, pix_valid;
    logic [14:0] mem_addr;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    bit          end_req = 1'b0;
    bit          end_done = 1'b0;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  g;
        logic        e;
        logic        w;
        logic [14:0] a;
        logic [7:0]  d;
    } gnt_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  rv;
        logic [7:0]  d;
    } rsp_t;

    typedef struct {
        int unsigned cyc;
        int          kind;    // 0: mem_addr, 1: {pix_valid, pix}, 2: all outputs
        logic [63:0] v;
        string       name;
    } chk_t;

    gnt_t q_gnt[$];
    rsp_t q_rsp[$];
    chk_t q_chk[$];

    vga_fb_arbiter #(.DW(8), .AW(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .CounterX    (CounterX),
        .CounterY    (CounterY),
        .vblank_only (vblank_only),
        .req         (req),
        .we          (we),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .err         (err),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix         (pix),
        .pix_valid   (pix_valid)
    );

    always #20 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM read data: low address byte XOR 0x5A, one cycle after mem_addr.
    always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

    task automatic step(input logic [9:0] x, input logic [9:0] y);
        CounterX = x;
        CounterY = y;
        @(negedge clk);
    endtask

    task automatic exp_gnt(input logic [1:0] g, input logic e, input logic w,
                           input logic [14:0] a, input logic [7:0] d);
        q_gnt.push_back('{cyc + 1, g, e, w, a, d});
    endtask

    task automatic exp_rsp(input logic [1:0] rv, input logic [7:0] d);
        q_rsp.push_back('{cyc + 2, rv, d});
    endtask

    task automatic exp_chk(input int kind, input logic [63:0] v, input string name);
        q_chk.push_back('{cyc + 1, kind, v, name});
    endtask

    // Monitor / scoreboard
    initial forever begin
        logic [58:0] act_g, exp_g;
        logic [41:0] act_r, exp_r;
        logic [63:0] act_c;
        gnt_t        eg;
        rsp_t        er;
        chk_t        ec;
        @(negedge clk);
        while (q_chk.size() != 0 && q_chk[0].cyc <= cyc) begin
            ec = q_chk.pop_front();
            n_cmp++;
            case (ec.kind)
                0:       act_c = 64'(mem_addr);
                1:       act_c = 64'({pix_valid, pix});
                default: act_c = 64'({gnt, rvalid, err, mem_we, pix_valid, pix, rdata,
                                      mem_addr, mem_wdata});
            endcase
            if (ec.cyc != cyc || act_c !== ec.v) begin
                n_fail++;
                $display("FAIL %s: cyc %0d got %h, required %h at cyc %0d",
                         ec.name, cyc, act_c, ec.v, ec.cyc);
            end
        end
        if (q_gnt.size() != 0 && q_gnt[0].cyc < cyc) begin
            eg = q_gnt.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL gnt_missing: no grant seen, required gnt=%b at cyc %0d", eg.g, eg.cyc);
        end
        if (gnt != 2'b00 || err || mem_we) begin
            n_cmp++;
            if (q_gnt.size() == 0) begin
                n_fail++;
                $display("FAIL gnt_unexpected: cyc %0d got gnt=%b err=%b mem_we=%b, required none",
                         cyc, gnt, err, mem_we);
            end else begin
                eg = q_gnt.pop_front();
                act_g = {cyc, gnt, err, mem_we, mem_addr, mem_wdata};
                exp_g = {eg.cyc, eg.g, eg.e, eg.w, eg.a, eg.d};
                if (act_g !== exp_g) begin
                    n_fail++;
                    $display("FAIL gnt: got cyc=%0d gnt=%b err=%b we=%b addr=%0d wd=%h, required cyc=%0d gnt=%b err=%b we=%b addr=%0d wd=%h",
                             cyc, gnt, err, mem_we, mem_addr, mem_wdata,
                             eg.cyc, eg.g, eg.e, eg.w, eg.a, eg.d);
                end
            end
        end
        if (q_rsp.size() != 0 && q_rsp[0].cyc < cyc) begin
            er = q_rsp.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL rsp_missing: no rvalid seen, required rvalid=%b at cyc %0d", er.rv, er.cyc);
        end
        if (rvalid != 2'b00) begin
            n_cmp++;
            if (q_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: cyc %0d got rvalid=%b rdata=%h, required none",
                         cyc, rvalid, rdata);
            end else begin
                er = q_rsp.pop_front();
                act_r = {cyc, rvalid, rdata};
                exp_r = {er.cyc, er.rv, er.d};
                if (act_r !== exp_r) begin
                    n_fail++;
                    $display("FAIL rsp: got cyc=%0d rvalid=%b rdata=%h, required cyc=%0d rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, er.cyc, er.rv, er.d);
                end
            end
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            n_cmp++;
            if (q_gnt.size() + q_rsp.size() + q_chk.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d/%0d/%0d pending gnt/rsp/chk, required 0/0/0",
                         q_gnt.size(), q_rsp.size(), q_chk.size());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required end within time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0]  b_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [14:0] b_a[4] = '{15'd100, 15'd200, 15'd100, 15'd200};
        logic [7:0]  b_w[4] = '{8'h11, 8'h22, 8'h11, 8'h22};
        logic [7:0]  b_d[4] = '{8'h3E, 8'h92, 8'h3E, 8'h92};   // 100^5A, 200^5A

        // Reset state, with requests asserted to show nothing is granted.
        repeat (2) @(negedge clk);
        req = 2'b11;
        exp_chk(2, 64'd0, "reset_outs");
        step(10'd700, 10'd500);
        req = 2'b00;
        reset = 1'b1;
        step(10'd700, 10'd500);

        // Display path: (X=8,Y=4) -> address 162, pixel 0xA2^0x5A = 0xF8.
        vblank_only = 1'b0;
        exp_chk(0, 64'd162, "disp_addr");
        step(10'd8, 10'd4);
        exp_chk(1, 64'h000, "pix_latency");
        step(10'd9, 10'd4);
        exp_chk(1, 64'h1F8, "pix_load");
        step(10'd10, 10'd4);
        step(10'd11, 10'd4);
        exp_chk(0, 64'd163, "disp_addr_next");
        step(10'd12, 10'd4);
        exp_chk(1, 64'h1F8, "pix_hold");
        step(10'd13, 10'd4);
        exp_chk(1, 64'h1F9, "pix_next");
        step(10'd14, 10'd4);

        // Both requesters reading during vblank: strict alternation from 0.
        vblank_only = 1'b1;
        we = 2'b00;
        addr0 = 15'd100;
        addr1 = 15'd200;
        wdata0 = 8'h11;
        wdata1 = 8'h22;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_gnt(b_g[i], 1'b0, 1'b0, b_a[i], b_w[i]);
            exp_rsp(b_g[i], b_d[i]);
            step(10'd700, 10'd500);
        end
        req = 2'b00;
        step(10'd700, 10'd500);
        step(10'd700, 10'd500);

        // Write raised in a display slot is deferred to the next cycle.
        vblank_only = 1'b0;
        step(10'd3, 10'd0);
        we = 2'b01;
        addr0 = 15'd500;
        wdata0 = 8'hA5;
        req = 2'b01;
        step(10'd4, 10'd0);
        exp_gnt(2'b01, 1'b0, 1'b1, 15'd500, 8'hA5);
        step(10'd5, 10'd0);
        req = 2'b00;
        we = 2'b00;
        step(10'd6, 10'd0);
        step(10'd7, 10'd0);
        step(10'd8, 10'd0);

        // vblank_only: request during the active line waits for X=640.
        vblank_only = 1'b1;
        addr1 = 15'd300;
        wdata1 = 8'h33;
        req = 2'b10;
        for (int x = 632; x < 640; x++) step(10'(x), 10'd100);
        exp_gnt(2'b10, 1'b0, 1'b0, 15'd300, 8'h33);
        exp_rsp(2'b10, 8'h76);                       // 0x2C ^ 0x5A
        step(10'd640, 10'd100);
        req = 2'b00;
        step(10'd641, 10'd100);
        step(10'd642, 10'd100);

        // Address range boundaries.
        addr0 = 15'd19200;
        wdata0 = 8'h44;
        req = 2'b01;
        exp_gnt(2'b01, 1'b1, 1'b0, 15'd19200, 8'h44);
        exp_rsp(2'b01, 8'h00);
        step(10'd700, 10'd500);
        req = 2'b00;
        step(10'd700, 10'd500);
        we = 2'b10;
        addr1 = 15'd20000;
        wdata1 = 8'h55;
        req = 2'b10;
        exp_gnt(2'b10, 1'b1, 1'b0, 15'd20000, 8'h55);
        step(10'd700, 10'd500);
        req = 2'b00;
        we = 2'b00;
        step(10'd700, 10'd500);
        addr0 = 15'd19199;
        req = 2'b01;
        exp_gnt(2'b01, 1'b0, 1'b0, 15'd19199, 8'h44);
        exp_rsp(2'b01, 8'hA5);                       // 0xFF ^ 0x5A
        step(10'd700, 10'd500);
        req = 2'b00;
        step(10'd700, 10'd500);
        step(10'd700, 10'd500);

        // Reset right after a read grant cancels its rvalid.
        addr0 = 15'd50;
        req = 2'b01;
        exp_gnt(2'b01, 1'b0, 1'b0, 15'd50, 8'h44);
        step(10'd700, 10'd500);
        #1;
        reset = 1'b0;
        req = 2'b00;
        exp_chk(2, 64'd0, "reset_mid");
        step(10'd700, 10'd500);
        reset = 1'b1;
        exp_chk(2, 64'd0, "reset_release");
        step(10'd700, 10'd500);

        // Pointer is back at 1: requester 0 wins the first tie.
        addr0 = 15'd60;
        addr1 = 15'd70;
        req = 2'b11;
        exp_gnt(2'b01, 1'b0, 1'b0, 15'd60, 8'h44);
        exp_rsp(2'b01, 8'h66);                       // 0x3C ^ 0x5A
        step(10'd700, 10'd500);
        exp_gnt(2'b10, 1'b0, 1'b0, 15'd70, 8'h55);
        exp_rsp(2'b10, 8'h1C);                       // 0x46 ^ 0x5A
        step(10'd700, 10'd500);
        req = 2'b00;
        step(10'd700, 10'd500);
        step(10'd700, 10'd500);

        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter DW, default 8, framebuffer word (pixel) width.
REQ-002 Parameter AW, default 15, framebuffer address width (160x120 = 19200 words).
REQ-003 clk  in  1  pixel clock, 25 MHz.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 CounterX  in  10  column count from the sync generator; wraps 0..800.
REQ-006 CounterY  in  10  line count from the sync generator; wraps 0..521.
REQ-007 vblank_only  in  1  when 1, requesters are served only outside the active area.
REQ-008 req[1:0]  in  2  per-requester access request, held until granted.
REQ-009 we[1:0]  in  2  per-requester write enable, qualified by req.
REQ-010 addr0, addr1  in  AW  requester word addresses.
REQ-011 wdata0, wdata1  in  DW  requester write data.
REQ-012 gnt[1:0]  out  2  one-cycle pulse; the access is issued on that cycle.
REQ-013 rvalid[1:0]  out  2  one-cycle pulse, one cycle after a read grant.
REQ-014 rdata  out  DW  read data, valid while any rvalid bit is 1.
REQ-015 err  out  1  one-cycle pulse on a grant with addr >= 19200.
REQ-016 mem_addr  out  AW, mem_we  out  1, mem_wdata  out  DW: single-port RAM controls, registered.
REQ-017 mem_rdata  in  DW  RAM read data, one-cycle latency after mem_addr.
REQ-018 pix  out  DW  display pixel; pix_valid  out  1  pix is in the active area.

Function
REQ-019 Display slot is the cycle where CounterX[1:0]==0, CounterX<640 and CounterY<480; the display read has absolute priority in that slot.
REQ-020 Display address is CounterY[9:2]*160 + CounterX[9:2], computed as shift-add; it never exceeds 19199.
REQ-021 pix loads mem_rdata 2 cycles after the display slot and holds for 4 cycles; pix_valid follows the same 2-cycle delay.
REQ-022 Non-display cycles are requester cycles; when vblank_only=1, only cycles with CounterX>=640 or CounterY>=480 are requester cycles.
REQ-023 The arbiter has states IDLE (no request or blocked cycle), GRANT (access issued) and RESP (read return pending); GRANT->RESP for reads only, and RESP->IDLE/GRANT after one cycle.
REQ-024 Round-robin: if both req are asserted, grant the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-025 At most one grant per cycle; back-to-back grants are allowed on consecutive requester cycles.
REQ-026 A request arriving in a display slot or a blocked cycle is deferred, not dropped; gnt is asserted in the first subsequent requester cycle.
REQ-027 A grant with addr >= 19200 pulses err, suppresses mem_we, and returns rdata=0 with rvalid for reads.
REQ-028 Write grant: mem_we=1 for exactly that cycle, with mem_wdata and mem_addr from the granted requester.
REQ-029 Requesters may change addr, we or wdata only after gnt; a req deasserted before grant is withdrawn with no access.

Reset
REQ-030 While reset=0: gnt, rvalid, err, mem_we and pix_valid are 0; pix, rdata, mem_addr and mem_wdata are 0; the state is IDLE; the pointer is 1.
REQ-031 Reset asserted mid-transaction cancels any pending rvalid; no grant is issued until 1 clk after reset deasserts.

Structure
REQ-032 A shared package holds FB_W=160, FB_H=120, FB_WORDS=19200, H_ACTIVE=640, V_ACTIVE=480 and the state enumeration.
REQ-033 One sub-module, rr_arb2, holds the 2-way round-robin pointer and grant logic; the slot qualification and datapath stay in vga_fb_arbiter.

Verification
REQ-034 CounterX=8, CounterY=4, mem_rdata = address pattern -> mem_addr=162 at the slot, and pix=pattern(162) 2 cycles later.
REQ-035 req=2'b11 held, both reads, during vblank -> gnt sequence 01,10,01,10 on consecutive cycles, with rvalid matching 1 cycle later.
REQ-036 req[0] write asserted at CounterX=4, CounterY=0, vblank_only=0 -> no gnt at the slot, gnt[0] at CounterX=5, mem_we=1 once.
REQ-037 vblank_only=1, req[1] raised at CounterY=100 -> gnt[1] first at CounterX=640 of that line.
REQ-038 req[0] read with addr0=19200 -> err=1 and gnt[0] in the same cycle, mem_we=0, rvalid[0]=1 with rdata=0 next cycle.
REQ-039 reset pulsed low 1 cycle after a read grant -> rvalid stays 0, all outputs 0, pointer=1 after release.
